// File: rtl/trapezoid_profile_checker_if.sv
// Sample stream and status bundle between the sampling front end / control and
// the trapezoid profile checker.
interface trapezoid_profile_checker_if #(
   parameter int DW = 16
);
   logic                 sample_valid;
   logic signed [DW-1:0] sample;
   logic                 clear_cnt;
   logic                 locked;
   logic [1:0]           phase;
   logic signed [DW-1:0] expected;
   logic                 err_pulse;
   logic                 period_done;
   logic [15:0]          err_count;

   modport master (
      output sample_valid, sample, clear_cnt,
      input  locked, phase, expected, err_pulse, period_done, err_count
   );

   modport slave (
      input  sample_valid, sample, clear_cnt,
      output locked, phase, expected, err_pulse, period_done, err_count
   );
endinterface

// File: rtl/trapezoid_profile_checker.sv
// Locks onto an Up/Hold/Down/Low trapezoid sample stream and checks every
// sample against the ideal profile within +/-TOL, reporting lock and errors.
module trapezoid_profile_checker #(
   parameter int DW       = 16,
   parameter int RAMP     = 20,
   parameter int TOL      = 2,
   parameter int LOCK_CNT = 2,
   parameter int MAX_ERR  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   trapezoid_profile_checker_if.slave   bus
);
   localparam int PERIOD = 4 * RAMP;
   localparam int PW     = $clog2(PERIOD);
   localparam int LW     = $clog2(RAMP / 2 + 1);
   localparam int GW     = $clog2(LOCK_CNT + 1);
   localparam int EW     = $clog2(MAX_ERR + 1);

   localparam logic [PW-1:0]        LAST   = PW'(PERIOD - 1);
   localparam logic signed [DW-1:0] TOL_S  = DW'(TOL);
   localparam logic signed [DW-1:0] NTOL_S = DW'(-TOL);
   localparam logic signed [DW:0]   TOL_W  = (DW + 1)'(TOL);
   localparam logic signed [DW:0]   NTOL_W = (DW + 1)'(-TOL);

   typedef enum logic [1:0] {SEARCH, ARM, TRACK} state_t;

   state_t               state_q, state_n;
   logic [PW-1:0]        pos_q, pos_n;
   logic [LW-1:0]        low_q, low_n;
   logic [GW-1:0]        good_q, good_n, good_sat;
   logic [EW-1:0]        perr_q, perr_n, perr_inc;
   logic                 locked_q, locked_n;
   logic [1:0]           phase_q, phase_n;
   logic signed [DW-1:0] exp_q, exp_n, chk_exp;
   logic                 errp_q, errp_n;
   logic                 pd_q, pd_n;
   logic [15:0]          cnt_q, cnt_n;
   logic signed [DW:0]   diff;
   logic                 mis, in_low;

   function automatic logic signed [DW-1:0] exp_of(input logic [PW-1:0] p);
      int q;
      q = int'(p);
      if (q < RAMP)          return DW'(q + 1);
      else if (q < 2 * RAMP) return DW'(RAMP);
      else if (q < 3 * RAMP) return DW'(3 * RAMP - 1 - q);
      else                   return '0;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SEARCH;
         pos_q    <= '0;
         low_q    <= '0;
         good_q   <= '0;
         perr_q   <= '0;
         locked_q <= 1'b0;
         phase_q  <= '0;
         exp_q    <= '0;
         errp_q   <= 1'b0;
         pd_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_n;
         pos_q    <= pos_n;
         low_q    <= low_n;
         good_q   <= good_n;
         perr_q   <= perr_n;
         locked_q <= locked_n;
         phase_q  <= phase_n;
         exp_q    <= exp_n;
         errp_q   <= errp_n;
         pd_q     <= pd_n;
         cnt_q    <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      pos_n    = pos_q;
      low_n    = low_q;
      good_n   = good_q;
      perr_n   = perr_q;
      locked_n = locked_q;
      phase_n  = phase_q;
      exp_n    = exp_q;
      errp_n   = 1'b0;
      pd_n     = 1'b0;
      cnt_n    = cnt_q;

      // ARM-entry sample is checked as position 0 of the profile
      chk_exp  = (state_q == TRACK) ? exp_of(pos_q) : exp_of('0);
      diff     = {bus.sample[DW-1], bus.sample} - {chk_exp[DW-1], chk_exp};
      mis      = (diff > TOL_W) || (diff < NTOL_W);
      in_low   = (bus.sample <= TOL_S) && (bus.sample >= NTOL_S);
      perr_inc = (mis && perr_q != EW'(MAX_ERR)) ? perr_q + EW'(1) : perr_q;
      good_sat = (good_q == GW'(LOCK_CNT)) ? good_q : good_q + GW'(1);

      if (bus.sample_valid) begin
         unique case (state_q)
            SEARCH: begin
               if (!in_low) begin
                  low_n = '0;
               end else if (low_q == LW'(RAMP / 2 - 1)) begin
                  low_n   = '0;
                  state_n = ARM;
               end else begin
                  low_n = low_q + LW'(1);
               end
            end
            ARM: begin
               if (bus.sample > TOL_S) begin
                  state_n = TRACK;
                  pos_n   = PW'(1);
                  phase_n = 2'b00;
                  exp_n   = chk_exp;
                  errp_n  = mis;
                  perr_n  = perr_inc;
               end else if (bus.sample < NTOL_S) begin
                  state_n = SEARCH;
               end
            end
            TRACK: begin
               phase_n = 2'(int'(pos_q) / RAMP);
               exp_n   = chk_exp;
               errp_n  = mis;
               pd_n    = (pos_q == LAST);
               if (perr_inc == EW'(MAX_ERR)) begin
                  state_n  = SEARCH;
                  locked_n = 1'b0;
                  good_n   = '0;
                  pos_n    = '0;
                  perr_n   = '0;
               end else if (pos_q == LAST) begin
                  pos_n  = '0;
                  perr_n = '0;
                  if (perr_inc == '0) begin
                     good_n   = good_sat;
                     locked_n = (good_sat == GW'(LOCK_CNT));
                  end else begin
                     good_n   = '0;
                     locked_n = 1'b0;
                  end
               end else begin
                  pos_n  = pos_q + PW'(1);
                  perr_n = perr_inc;
               end
            end
            default: state_n = SEARCH;
         endcase
      end

      if (bus.clear_cnt)                 cnt_n = '0;
      else if (errp_n && cnt_q != '1)    cnt_n = cnt_q + 16'd1;
   end

   assign bus.locked      = locked_q;
   assign bus.phase       = phase_q;
   assign bus.expected    = exp_q;
   assign bus.err_pulse   = errp_q;
   assign bus.period_done = pd_q;
   assign bus.err_count   = cnt_q;
endmodule

// File: tb/tb_trapezoid_profile_checker.sv
// Scenario bench for trapezoid_profile_checker: a behavioural model feeds a
// scoreboard queue, and each scenario task adds its own targeted checks.
module tb_trapezoid_profile_checker;
   localparam int DW = 16, R = 20, TOL = 2, LOCKN = 2, MAXE = 8, PER = 4 * R;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   trapezoid_profile_checker_if #(.DW(DW)) bus ();

   trapezoid_profile_checker #(
      .DW(DW), .RAMP(R), .TOL(TOL), .LOCK_CNT(LOCKN), .MAX_ERR(MAXE)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic        locked;
      logic [1:0]  phase;
      logic [15:0] expected;
      logic        errp;
      logic        pd;
      logic [15:0] cnt;
      bit          chk_cnt;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_it;
   int   errors = 0;
   int   checks = 0;
   bit   chk_cnt = 1'b1;

   int         m_state, m_pos, m_low, m_good, m_perr, m_exp, m_cnt;
   logic       m_locked, m_errp, m_pd;
   logic [1:0] m_phase;

   function automatic int exp_of(input int p);
      if (p < R)     return p + 1;
      if (p < 2 * R) return R;
      if (p < 3 * R) return 3 * R - 1 - p;
      return 0;
   endfunction

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   task automatic model_reset();
      m_state = 0; m_pos = 0; m_low = 0; m_good = 0; m_perr = 0;
      m_exp = 0; m_cnt = 0; m_locked = 1'b0; m_errp = 1'b0; m_pd = 1'b0;
      m_phase = 2'b00;
   endtask

   // State codes: 0 search, 1 armed, 2 tracking
   task automatic model_step(input bit v, input int s, input bit clr);
      int e, pn;
      bit mis;
      m_errp = 1'b0;
      m_pd   = 1'b0;
      if (v) begin
         case (m_state)
            0: begin
               if (iabs(s) <= TOL) begin
                  m_low++;
                  if (m_low == R / 2) begin m_state = 1; m_low = 0; end
               end else m_low = 0;
            end
            1: begin
               if (s > TOL) begin
                  mis = iabs(s - exp_of(0)) > TOL;
                  m_errp = mis; m_perr = mis ? 1 : 0;
                  m_phase = 2'b00; m_exp = exp_of(0); m_pos = 1; m_state = 2;
               end else if (s < -TOL) m_state = 0;
            end
            default: begin
               e = exp_of(m_pos);
               mis = iabs(s - e) > TOL;
               m_errp = mis; m_phase = 2'(m_pos / R); m_exp = e;
               pn = m_perr + (mis ? 1 : 0);
               if (pn > MAXE) pn = MAXE;
               m_pd = (m_pos == PER - 1);
               if (pn == MAXE) begin
                  m_state = 0; m_locked = 1'b0; m_good = 0; m_pos = 0; m_perr = 0;
               end else if (m_pd) begin
                  m_pos = 0; m_perr = 0;
                  if (pn == 0) begin
                     if (m_good < LOCKN) m_good++;
                     m_locked = (m_good == LOCKN);
                  end else begin
                     m_good = 0; m_locked = 1'b0;
                  end
               end else begin
                  m_pos++; m_perr = pn;
               end
            end
         endcase
      end
      if (clr) m_cnt = 0;
      else if (m_errp && m_cnt < 65535) m_cnt++;
   endtask

   // Called at a falling edge; returns at the next falling edge
   task automatic step(input bit v, input int s, input bit clr);
      exp_t it;
      bus.sample_valid = v;
      bus.sample       = 16'(s);
      bus.clear_cnt    = clr;
      model_step(v, s, clr);
      it.locked = m_locked; it.phase = m_phase; it.expected = 16'(m_exp);
      it.errp = m_errp; it.pd = m_pd; it.cnt = 16'(m_cnt); it.chk_cnt = chk_cnt;
      sbq.push_back(it);
      @(posedge clk);
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.clear_cnt    = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (sbq.size() > 0) begin
         mon_it = sbq.pop_front();
         checks += 5;
         if (bus.locked !== mon_it.locked) begin
            errors++; $display("FAIL sb_locked t=%0t got %0b want %0b", $time, bus.locked, mon_it.locked);
         end
         if (bus.phase !== mon_it.phase) begin
            errors++; $display("FAIL sb_phase t=%0t got %0d want %0d", $time, bus.phase, mon_it.phase);
         end
         if (bus.expected !== mon_it.expected) begin
            errors++; $display("FAIL sb_expected t=%0t got %0d want %0d", $time, bus.expected, $signed(mon_it.expected));
         end
         if (bus.err_pulse !== mon_it.errp) begin
            errors++; $display("FAIL sb_err_pulse t=%0t got %0b want %0b", $time, bus.err_pulse, mon_it.errp);
         end
         if (bus.period_done !== mon_it.pd) begin
            errors++; $display("FAIL sb_period_done t=%0t got %0b want %0b", $time, bus.period_done, mon_it.pd);
         end
         if (mon_it.chk_cnt) begin
            checks++;
            if (bus.err_count !== mon_it.cnt) begin
               errors++; $display("FAIL sb_err_count t=%0t got %0d want %0d", $time, bus.err_count, mon_it.cnt);
            end
         end
      end
   end

   // Ten zeros followed by nper ideal periods, with gap invalid cycles after each sample
   task automatic feed_trap(input int nper, input int gap, output int npd, output int nerr,
                            output logic [2:0] lk_at_pd);
      int s;
      npd = 0; nerr = 0; lk_at_pd = '0;
      for (int i = 0; i < 10 + nper * PER; i++) begin
         s = (i < 10) ? 0 : exp_of((i - 10) % PER);
         step(1'b1, s, 1'b0);
         if (bus.err_pulse) nerr++;
         if (bus.period_done) begin
            if (npd < 3) lk_at_pd[npd] = bus.locked;
            npd++;
         end
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 777, 1'b0);
            if (bus.err_pulse || bus.period_done) nerr++;
         end
      end
   endtask

   // Clean tracked samples until n period_done pulses; returns 0 on timeout
   task automatic run_clean(input int n, output bit ok);
      int seen = 0;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         step(1'b1, exp_of(m_pos), 1'b0);
         if (bus.period_done) seen++;
         if (seen == n) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.sample_valid = 1'b0; bus.sample = '0; bus.clear_cnt = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks += 6;
      if (bus.locked !== 1'b0)      begin errors++; $display("FAIL reset_locked got %0b want 0", bus.locked); end
      if (bus.phase !== 2'b00)      begin errors++; $display("FAIL reset_phase got %0d want 0", bus.phase); end
      if (bus.expected !== 16'sd0)  begin errors++; $display("FAIL reset_expected got %0d want 0", bus.expected); end
      if (bus.err_pulse !== 1'b0)   begin errors++; $display("FAIL reset_err_pulse got %0b want 0", bus.err_pulse); end
      if (bus.period_done !== 1'b0) begin errors++; $display("FAIL reset_period_done got %0b want 0", bus.period_done); end
      if (bus.err_count !== 16'd0)  begin errors++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lock(input int gap, input string tag);
      int npd, nerr;
      logic [2:0] lk;
      feed_trap(3, gap, npd, nerr, lk);
      checks += 5;
      if (npd !== 2)               begin errors++; $display("FAIL %s_pd_count got %0d want 2", tag, npd); end
      if (lk[0] !== 1'b0)          begin errors++; $display("FAIL %s_locked_pd1 got %0b want 0", tag, lk[0]); end
      if (lk[1] !== 1'b1)          begin errors++; $display("FAIL %s_locked_pd2 got %0b want 1", tag, lk[1]); end
      if (nerr !== 0)              begin errors++; $display("FAIL %s_errors got %0d want 0", tag, nerr); end
      if (bus.err_count !== 16'd0) begin errors++; $display("FAIL %s_err_count got %0d want 0", tag, bus.err_count); end
   endtask

   task automatic test_async_reset_sparse();
      #2 rst_n = 1'b0;
      #1;
      checks += 3;
      if (bus.locked !== 1'b0)     begin errors++; $display("FAIL async_locked got %0b want 0", bus.locked); end
      if (bus.phase !== 2'b00)     begin errors++; $display("FAIL async_phase got %0d want 0", bus.phase); end
      if (bus.expected !== 16'sd0) begin errors++; $display("FAIL async_expected got %0d want 0", bus.expected); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_lock(2, "sparse");
   endtask

   task automatic test_hold_error();
      bit injected = 1'b0, done = 1'b0, inj;
      int ne = 0, s;
      for (int i = 0; i < 200 && !done; i++) begin
         inj = (m_pos == 30) && !injected;
         s = inj ? 23 : exp_of(m_pos);
         step(1'b1, s, 1'b0);
         if (bus.err_pulse) ne++;
         if (inj) begin
            injected = 1'b1;
            checks += 2;
            if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL hold_err_pulse got %0b want 1", bus.err_pulse); end
            if (bus.locked !== 1'b1)    begin errors++; $display("FAIL hold_locked_before_wrap got %0b want 1", bus.locked); end
         end else if (bus.period_done && injected) done = 1'b1;
      end
      checks += 4;
      if (!done)                   begin errors++; $display("FAIL hold_timeout got 0 want 1"); end
      if (ne !== 1)                begin errors++; $display("FAIL hold_err_pulses got %0d want 1", ne); end
      if (bus.err_count !== 16'd1) begin errors++; $display("FAIL hold_err_count got %0d want 1", bus.err_count); end
      if (bus.locked !== 1'b0)     begin errors++; $display("FAIL hold_locked_after_wrap got %0b want 0", bus.locked); end
   endtask

   task automatic test_flat_loss();
      bit ok;
      int ne = 0, npd, nerr;
      logic [2:0] lk;
      run_clean(2, ok);
      checks += 2;
      if (!ok)                 begin errors++; $display("FAIL relock_timeout got 0 want 1"); end
      if (bus.locked !== 1'b1) begin errors++; $display("FAIL relock_locked got %0b want 1", bus.locked); end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 100, 1'b0);
         if (bus.err_pulse) ne++;
      end
      checks += 3;
      if (ne !== 8)                begin errors++; $display("FAIL flat_err_pulses got %0d want 8", ne); end
      if (bus.locked !== 1'b0)     begin errors++; $display("FAIL flat_locked got %0b want 0", bus.locked); end
      if (bus.err_count !== 16'd9) begin errors++; $display("FAIL flat_err_count got %0d want 9", bus.err_count); end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 100, 1'b0);
         checks++;
         if (bus.err_pulse !== 1'b0) begin errors++; $display("FAIL search_err_pulse got %0b want 0", bus.err_pulse); end
      end
      feed_trap(3, 0, npd, nerr, lk);
      checks += 3;
      if (npd !== 2)      begin errors++; $display("FAIL resync_pd_count got %0d want 2", npd); end
      if (lk[1] !== 1'b1) begin errors++; $display("FAIL resync_locked got %0b want 1", lk[1]); end
      if (nerr !== 0)     begin errors++; $display("FAIL resync_errors got %0d want 0", nerr); end
   endtask

   task automatic test_noise();
      bit ok, inj;
      int ne = 0, ninj = 0, n;
      run_clean(1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL noise_align_timeout got 0 want 1"); end
      for (int i = 0; i < PER; i++) begin
         n = int'($urandom_range(0, 4)) - 2;
         step(1'b1, exp_of(m_pos) + n, 1'b0);
         if (bus.err_pulse) ne++;
      end
      checks += 3;
      if (ne !== 0)                 begin errors++; $display("FAIL noise2_err_pulses got %0d want 0", ne); end
      if (bus.period_done !== 1'b1) begin errors++; $display("FAIL noise2_period_done got %0b want 1", bus.period_done); end
      if (bus.locked !== 1'b1)      begin errors++; $display("FAIL noise2_locked got %0b want 1", bus.locked); end
      ne = 0;
      for (int i = 0; i < PER; i++) begin
         inj = (m_pos % 16) == 5;
         n = inj ? (ninj[0] ? -3 : 3) : int'($urandom_range(0, 4)) - 2;
         step(1'b1, exp_of(m_pos) + n, 1'b0);
         if (bus.err_pulse) ne++;
         if (inj) begin
            ninj++;
            checks++;
            if (bus.err_pulse !== 1'b1) begin errors++; $display("FAIL noise3_err_pulse got %0b want 1", bus.err_pulse); end
         end
      end
      checks += 3;
      if (ne !== 5)            begin errors++; $display("FAIL noise3_err_pulses got %0d want 5", ne); end
      if (ninj !== 5)          begin errors++; $display("FAIL noise3_injected got %0d want 5", ninj); end
      if (bus.locked !== 1'b0) begin errors++; $display("FAIL noise3_locked got %0b want 0", bus.locked); end
   endtask

   task automatic test_saturation();
      chk_cnt = 1'b0;
      force dut.cnt_q = 16'hFFFE;
      step(1'b1, exp_of(m_pos) + 50, 1'b0);
      release dut.cnt_q;
      step(1'b1, exp_of(m_pos) + 50, 1'b0);
      step(1'b1, exp_of(m_pos) + 50, 1'b0);
      checks += 2;
      if (bus.err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_err_count got %0h want ffff", bus.err_count); end
      if (bus.err_pulse !== 1'b1)     begin errors++; $display("FAIL sat_err_pulse got %0b want 1", bus.err_pulse); end
      m_cnt = 16'hFFFF;
      chk_cnt = 1'b1;
      step(1'b1, exp_of(m_pos) + 50, 1'b1);
      checks += 2;
      if (bus.err_count !== 16'd0) begin errors++; $display("FAIL clear_err_count got %0d want 0", bus.err_count); end
      if (bus.err_pulse !== 1'b1)  begin errors++; $display("FAIL clear_err_pulse got %0b want 1", bus.err_pulse); end
      step(1'b0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_lock(0, "ideal");
      test_async_reset_sparse();
      test_hold_error();
      test_flat_loss();
      test_noise();
      test_saturation();
      repeat (3) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin errors++; $display("FAIL sb_drain got %0d want 0", sbq.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
